f1_light_sequencer: RTL and testbench

//  Parametrised F1 start-light controller with a built-in reaction timer.
//  - On trigger: fills NUM_LIGHTS lamps one per tick, holds all lamps on for a pseudo-random number of ticks, then blanks them.
//  - After the blank: counts ticks until the driver presses react, and flags a jump start if react comes before the blank.
//  - Sits between the board's push-button/lamp bar and the display/score logic.

---
 rtl/f1_pkg.sv | 48 ++++
 rtl/f1_lfsr.sv | 30 +++
 rtl/f1_light_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_f1_light_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light sequencer.
package f1_pkg;

  // Sequencer states; DONE and FAULT behave like IDLE but keep their outputs.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEQ   = 3'd1,
    HOLD  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } f1_state_t;

  // Supported LFSR widths.
  localparam int LFSR_W_MIN = 4;
  localparam int LFSR_W_MAX = 16;

  // Maximal-length Fibonacci tap masks; bit (n-1) set means tap n is used.
  // The register shifts towards the MSB with the XOR of the tapped bits entering
  // at bit0. Widths outside 4..16 get an all-zero mask.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    t = 16'h0000;
    case (w)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // A run is in progress in SEQ, HOLD and OUT.
  function automatic logic is_busy(input f1_state_t s);
    return (s == SEQ) || (s == HOLD) || (s == OUT);
  endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR used to randomise the all-lamps-on hold time.
// Resets to 1 and never reaches 0.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] r_q;
  logic         w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign q    = r_q;

  // Advance every cycle; the seed of 1 keeps the register off the all-zero lockup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= W'(1);
    end else begin
      r_q <= {r_q[W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light controller with reaction timer.
// A trigger fills the lamp bar one lamp per tick, holds it for a random number
// of ticks, blanks it, then counts ticks until the driver reacts. A react
// before the blank is a jump start.
//
// rt_valid is a one-cycle strobe with no ready: rt_count is final and stable
// on the strobe cycle and stays held until the next run starts, so a consumer
// may sample it on the strobe or any later cycle.
//
// NUM_LIGHTS must be 2..32, LFSR_W 4..16 and MIN_HOLD below 2**LFSR_W.
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = 8,
  parameter int DIV_W      = 16,
  parameter int LFSR_W     = 7,
  parameter int RT_W       = 16,
  parameter int MIN_HOLD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  react,
  input  logic [DIV_W-1:0]      div_n,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic                  rt_valid,
  output logic [RT_W-1:0]       rt_count,
  output logic                  jump_start,
  output f1_state_t             dbg_state
);

  // One spare bit so lfsr + MIN_HOLD cannot overflow.
  localparam int HOLD_W = LFSR_W + 1;

  localparam logic [HOLD_W-1:0]     HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]     HOLD_MIN = HOLD_W'(MIN_HOLD);
  localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
  localparam logic [RT_W-1:0]       RT_ONE   = RT_W'(1);
  localparam logic [RT_W-1:0]       RT_MAX   = '1;
  localparam logic [NUM_LIGHTS-1:0] ALL_ON   = '1;

  f1_state_t             r_state;
  f1_state_t             w_next;
  logic [DIV_W-1:0]      r_div_q;
  logic [DIV_W-1:0]      r_presc;
  logic [HOLD_W-1:0]     r_hold_len;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [NUM_LIGHTS-1:0] r_lights;
  logic [RT_W-1:0]       r_rt_count;
  logic                  r_rt_valid;
  logic                  r_jump;
  logic [LFSR_W-1:0]     w_lfsr;

  logic w_busy;
  logic w_tick;
  logic w_state_chg;
  logic w_start;
  logic w_fault;
  logic w_done;
  logic w_to_hold;
  logic w_to_out;
  logic w_rt_full;
  logic w_hold_last;

  f1_lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (w_lfsr)
  );

  assign w_busy      = is_busy(r_state);
  assign w_tick      = w_busy && (r_presc == r_div_q);
  assign w_state_chg = (w_next != r_state);
  assign w_rt_full   = (r_rt_count == RT_MAX);
  assign w_hold_last = ((r_hold_cnt + HOLD_ONE) == r_hold_len);

  // Next-state and per-transition strobes. react is checked before the tick so
  // that a react on the HOLD->OUT cycle is a jump start and a react coinciding
  // with an OUT tick ends the run without counting that tick.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_fault   = 1'b0;
    w_done    = 1'b0;
    w_to_hold = 1'b0;
    w_to_out  = 1'b0;
    unique case (r_state)
      IDLE, DONE, FAULT: begin
        if (trigger) begin
          w_next  = SEQ;
          w_start = 1'b1;
        end
      end
      SEQ: begin
        if (react) begin
          w_next  = FAULT;
          w_fault = 1'b1;
        end else if (w_tick && r_lights[NUM_LIGHTS-2]) begin
          w_next    = HOLD;
          w_to_hold = 1'b1;
        end
      end
      HOLD: begin
        if (react) begin
          w_next  = FAULT;
          w_fault = 1'b1;
        end else if (w_tick && w_hold_last) begin
          w_next   = OUT;
          w_to_out = 1'b1;
        end
      end
      OUT: begin
        if (react || w_rt_full) begin
          w_next = DONE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Tick period is frozen at run start so mid-run div_n changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_q <= '0;
    end else if (w_start) begin
      r_div_q <= div_n;
    end
  end

  // Prescaler: runs only while busy, restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_state_chg || !w_busy || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + DIV_ONE;
    end
  end

  // Hold length is sampled from the LFSR as the last lamp lights; ticks are then counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_len <= '0;
      r_hold_cnt <= '0;
    end else if (w_to_hold) begin
      r_hold_len <= {1'b0, w_lfsr} + HOLD_MIN;
      r_hold_cnt <= '0;
    end else if ((r_state == HOLD) && w_tick) begin
      r_hold_cnt <= r_hold_cnt + HOLD_ONE;
    end
  end

  // Lamp bar: cleared at run start, filled from bit0 in SEQ, all on for a
  // jump start, dark from the blank onwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lights <= '0;
    end else if (w_start) begin
      r_lights <= '0;
    end else if (w_fault) begin
      r_lights <= ALL_ON;
    end else if (w_to_out) begin
      r_lights <= '0;
    end else if ((r_state == SEQ) && w_tick) begin
      r_lights <= {r_lights[NUM_LIGHTS-2:0], 1'b1};
    end
  end

  // Reaction counter saturates at all-ones; the exit to DONE handles the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rt_count <= '0;
    end else if (w_start) begin
      r_rt_count <= '0;
    end else if ((r_state == OUT) && !react && w_tick && !w_rt_full) begin
      r_rt_count <= r_rt_count + RT_ONE;
    end
  end

  // Result strobe and sticky jump-start flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rt_valid <= 1'b0;
      r_jump     <= 1'b0;
    end else begin
      r_rt_valid <= w_done;
      if (w_start) begin
        r_jump <= 1'b0;
      end else if (w_fault) begin
        r_jump <= 1'b1;
      end
    end
  end

  assign lights     = r_lights;
  assign busy       = w_busy;
  assign rt_valid   = r_rt_valid;
  assign rt_count   = r_rt_count;
  assign jump_start = r_jump;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Directed bench for f1_light_sequencer with NUM_LIGHTS=5, LFSR_W=4,
// MIN_HOLD=2, RT_W=8.
module tb_f1_light_sequencer;
  import f1_pkg::*;

  localparam int NL    = 5;
  localparam int DIV_W = 16;
  localparam int LW    = 4;
  localparam int RT_W  = 8;

  logic             clk;
  logic             rst;
  logic             trigger;
  logic             react;
  logic [DIV_W-1:0] div_n;
  logic [NL-1:0]    lights;
  logic             busy;
  logic             rt_valid;
  logic [RT_W-1:0]  rt_count;
  logic             jump_start;
  f1_state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hl     = 0;
  int guard  = 0;

  // Hand-derived 4-bit sequence (taps 4,3) starting from the reset seed of 1.
  int seq_tab[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  f1_light_sequencer #(
    .NUM_LIGHTS(NL),
    .DIV_W     (DIV_W),
    .LFSR_W    (LW),
    .RT_W      (RT_W),
    .MIN_HOLD  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .react     (react),
    .div_n     (div_n),
    .lights    (lights),
    .busy      (busy),
    .rt_valid  (rt_valid),
    .rt_count  (rt_count),
    .jump_start(jump_start),
    .dbg_state (dbg_state)
  );

  // Clock and reset-relative edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; react = 1'b0; div_n = '0;
    #1 rst = 1'b0;
    #11;
    // Reset state
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_lights", 32'(lights), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rt_valid", 32'(rt_valid), 32'h0);
    chk("rst_rt_count", 32'(rt_count), 32'h0);
    chk("rst_jump", 32'(jump_start), 32'h0);
    chk("rst_lfsr", 32'(dut.w_lfsr), 32'h1);
    rst = 1'b1;
    step(1);

    // react in IDLE is ignored
    react = 1'b1; step(1); react = 1'b0;
    chk("idle_react_state", 32'(dbg_state), 32'(IDLE));
    chk("idle_react_jump", 32'(jump_start), 32'h0);

    // Fill sequence at one tick per cycle
    div_n = 16'd0;
    pulse_trigger();
    chk("t1_state_seq", 32'(dbg_state), 32'(SEQ));
    chk("t1_lights0", 32'(lights), 32'h0);
    chk("t1_busy0", 32'(busy), 32'h1);
    for (int k = 1; k <= NL; k++) begin
      step(1);
      chk("t1_lights", 32'(lights), 32'((1 << k) - 1));
      chk("t1_busy", 32'(busy), 32'h1);
    end
    chk("t1_state_hold", 32'(dbg_state), 32'(HOLD));
    hl = seq_tab[(cyc - 1) % 15] + 2;
    step(hl - 1);
    chk("t1_hold_end", 32'(dbg_state), 32'(HOLD));
    chk("t1_hold_lights", 32'(lights), 32'h1f);
    step(1);
    chk("t1_out", 32'(dbg_state), 32'(OUT));
    chk("t1_out_lights", 32'(lights), 32'h0);
    chk("t1_out_rt", 32'(rt_count), 32'h0);

    // No react: counter saturates and finishes once
    step(255);
    chk("t4_rt_255", 32'(rt_count), 32'd255);
    chk("t4_still_out", 32'(dbg_state), 32'(OUT));
    chk("t4_no_valid_yet", 32'(rt_valid), 32'h0);
    step(1);
    chk("t4_done", 32'(dbg_state), 32'(DONE));
    chk("t4_valid", 32'(rt_valid), 32'h1);
    chk("t4_rt_sat", 32'(rt_count), 32'd255);
    chk("t4_busy", 32'(busy), 32'h0);
    step(1);
    chk("t4_valid_once", 32'(rt_valid), 32'h0);
    chk("t4_rt_held", 32'(rt_count), 32'd255);
    react = 1'b1; step(1); react = 1'b0;
    chk("t4_done_react_ign", 32'(dbg_state), 32'(DONE));
    chk("t4_done_valid_low", 32'(rt_valid), 32'h0);

    // div_n=3 aligned so the hold sample is 5; div_n changed mid-run
    div_n = 16'd3;
    guard = 0;
    while (((cyc % 15) != 3) && (guard < 20)) begin
      step(1);
      guard++;
    end
    pulse_trigger();
    div_n = 16'd0;
    chk("t2_seq", 32'(dbg_state), 32'(SEQ));
    chk("t2_rt_cleared", 32'(rt_count), 32'h0);
    step(3);
    chk("t6_div_frozen", 32'(lights), 32'h0);
    step(1);
    chk("t2_lamp1", 32'(lights), 32'h1);
    step(16);
    chk("t2_hold", 32'(dbg_state), 32'(HOLD));
    chk("t2_all_on", 32'(lights), 32'h1f);
    step(27);
    chk("t2_hold_27", 32'(dbg_state), 32'(HOLD));
    step(1);
    chk("t2_out_28", 32'(dbg_state), 32'(OUT));
    chk("t2_blank", 32'(lights), 32'h0);
    step(12);
    chk("t2_rt3", 32'(rt_count), 32'd3);
    react = 1'b1; step(1); react = 1'b0;
    chk("t2_done", 32'(dbg_state), 32'(DONE));
    chk("t2_valid", 32'(rt_valid), 32'h1);
    chk("t2_rt_final", 32'(rt_count), 32'd3);
    step(1);
    chk("t2_valid_drop", 32'(rt_valid), 32'h0);
    chk("t2_rt_held", 32'(rt_count), 32'd3);

    // Jump start in HOLD
    div_n = 16'd1;
    pulse_trigger();
    chk("t3_seq", 32'(dbg_state), 32'(SEQ));
    chk("t3_rt_cleared", 32'(rt_count), 32'h0);
    step(10);
    chk("t3_hold", 32'(dbg_state), 32'(HOLD));
    step(3);
    react = 1'b1; step(1); react = 1'b0;
    chk("t3_fault", 32'(dbg_state), 32'(FAULT));
    chk("t3_jump", 32'(jump_start), 32'h1);
    chk("t3_lights", 32'(lights), 32'h1f);
    chk("t3_busy", 32'(busy), 32'h0);
    react = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t3_no_valid", 32'(rt_valid), 32'h0);
      chk("t3_fault_held", 32'(dbg_state), 32'(FAULT));
    end
    react = 1'b0;

    // Trigger held high through SEQ, then jump start in SEQ
    div_n = 16'd2;
    trigger = 1'b1;
    step(1);
    chk("t6_seq", 32'(dbg_state), 32'(SEQ));
    chk("t3_jump_cleared", 32'(jump_start), 32'h0);
    chk("t6_lights_clr", 32'(lights), 32'h0);
    step(3);
    chk("t6_lamp1", 32'(lights), 32'h1);
    step(3);
    chk("t6_no_restart", 32'(lights), 32'h3);
    trigger = 1'b0;
    react = 1'b1; step(1); react = 1'b0;
    chk("t6_seq_fault", 32'(dbg_state), 32'(FAULT));
    chk("t6_seq_fault_lights", 32'(lights), 32'h1f);
    chk("t6_seq_fault_jump", 32'(jump_start), 32'h1);

    // react and tick on the same OUT cycle
    div_n = 16'd1;
    pulse_trigger();
    step(10);
    chk("t6b_hold", 32'(dbg_state), 32'(HOLD));
    hl = seq_tab[(cyc - 1) % 15] + 2;
    step(2 * hl);
    chk("t6b_out", 32'(dbg_state), 32'(OUT));
    step(4);
    chk("t6b_rt2", 32'(rt_count), 32'd2);
    step(1);
    react = 1'b1; step(1); react = 1'b0;
    chk("t6b_done", 32'(dbg_state), 32'(DONE));
    chk("t6b_tick_dropped", 32'(rt_count), 32'd2);
    chk("t6b_valid", 32'(rt_valid), 32'h1);

    // react on the HOLD->OUT cycle is a jump start
    div_n = 16'd0;
    pulse_trigger();
    step(5);
    chk("t6c_hold", 32'(dbg_state), 32'(HOLD));
    hl = seq_tab[(cyc - 1) % 15] + 2;
    step(hl - 1);
    chk("t6c_hold_last", 32'(dbg_state), 32'(HOLD));
    react = 1'b1; step(1); react = 1'b0;
    chk("t6c_fault", 32'(dbg_state), 32'(FAULT));
    chk("t6c_jump", 32'(jump_start), 32'h1);
    chk("t6c_lights", 32'(lights), 32'h1f);
    chk("t6c_no_valid", 32'(rt_valid), 32'h0);

    // Asynchronous reset in the middle of SEQ
    div_n = 16'd3;
    pulse_trigger();
    step(4);
    chk("t5_lamp1", 32'(lights), 32'h1);
    #3 rst = 1'b0;
    #1;
    chk("t5_lights_dark", 32'(lights), 32'h0);
    chk("t5_busy_low", 32'(busy), 32'h0);
    chk("t5_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("t5_lfsr_seed", 32'(dut.w_lfsr), 32'h1);
    #2 rst = 1'b1;
    step(1);
    chk("t5_lfsr_next", 32'(dut.w_lfsr), 32'h2);
    chk("t5_idle_after", 32'(dbg_state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
